// File: rtl/pool_window_gather_if.sv
// Stream-in / window-out bundle between the pixel feeder, the 2x2 window
// gatherer and the max-pool comparator. The feeder drives the pixel stream
// (master). The gatherer consumes the pixels and produces the four-pixel
// window (slave).
interface pool_window_gather_if #(
  parameter int DATA_W = 8
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     win_valid;
  logic signed [DATA_W-1:0] win0;
  logic signed [DATA_W-1:0] win1;
  logic signed [DATA_W-1:0] win2;
  logic signed [DATA_W-1:0] win3;
  logic                     win_last;

  modport master (
    output in_valid, in_data,
    input  win_valid, win0, win1, win2, win3, win_last
  );

  modport slave (
    input  in_valid, in_data,
    output win_valid, win0, win1, win2, win3, win_last
  );
endinterface

// File: rtl/pool_window_gather.sv
// 2x2 stride-2 window gatherer for a raster-order feature-map stream.
// Even rows are stored in a one-row line buffer. On odd rows the bottom-left
// pixel is held in a register. The bottom-right pixel completes a window,
// which is presented one cycle later together with the three stored pixels.
module pool_window_gather #(
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  pool_window_gather_if.slave bus
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]         col;
  logic [COL_W-1:0]         col_pair;
  logic [ROW_W-1:0]         row;
  logic signed [DATA_W-1:0] line_buf [IMG_W];
  logic signed [DATA_W-1:0] bl;
  logic                     odd_row;
  logic                     odd_col;
  logic                     col_wrap;
  logic                     row_wrap;

  assign odd_row  = row[0];
  assign odd_col  = col[0];
  assign col_wrap = (col == COL_LAST);
  assign row_wrap = (row == ROW_LAST);
  // When col is odd, flipping bit 0 gives the even column of the same window.
  assign col_pair = col ^ COL_W'(1);

  // Capture every accepted even-row pixel as the top row of the next windows.
  always_ff @(posedge clk) begin
    if (!rst && bus.in_valid && !odd_row) begin
      line_buf[col] <= bus.in_data;
    end
  end

  // Advance the raster position, hold the bottom-left pixel, and emit a window.
  always_ff @(posedge clk) begin
    if (rst) begin
      col           <= '0;
      row           <= '0;
      bl            <= '0;
      bus.win_valid <= 1'b0;
      bus.win_last  <= 1'b0;
      bus.win0      <= '0;
      bus.win1      <= '0;
      bus.win2      <= '0;
      bus.win3      <= '0;
    end else begin
      bus.win_valid <= 1'b0;
      bus.win_last  <= 1'b0;
      if (bus.in_valid) begin
        if (odd_row && !odd_col) begin
          bl <= bus.in_data;
        end
        if (odd_row && odd_col) begin
          bus.win0      <= line_buf[col_pair];
          bus.win1      <= line_buf[col];
          bus.win2      <= bl;
          bus.win3      <= bus.in_data;
          bus.win_valid <= 1'b1;
          bus.win_last  <= col_wrap && row_wrap;
        end
        if (col_wrap) begin
          col <= '0;
          if (row_wrap) begin
            row <= '0;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/pool_window_gather.md
# pool_window_gather

Upstream feeder for the 2x2 max-pool comparator. Accepts the convolution layer's output feature map as a raster-order stream of signed 8-bit pixels, one per valid cycle. Buffers one row of pixels and, for every non-overlapping 2x2 block (stride 2), presents the four window pixels in a fixed order with a one-cycle valid pulse. The four window outputs connect directly to the comparator's four inputs.

## Interface
- IMG_W, 24, conv feature-map width in pixels; must be even and >= 2
- IMG_H, 24, conv feature-map height in rows; must be even and >= 2
- DATA_W, 8, pixel width, signed two's complement

- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data carries a pixel this cycle
- in_data  in  DATA_W signed  conv pixel, raster order (row 0 col 0 first)
- win_valid  out  1  window outputs valid this cycle (single-cycle pulse)
- win0  out  DATA_W signed  top-left pixel (row 2r, col 2c)
- win1  out  DATA_W signed  top-right pixel (row 2r, col 2c+1)
- win2  out  DATA_W signed  bottom-left pixel (row 2r+1, col 2c)
- win3  out  DATA_W signed  bottom-right pixel (row 2r+1, col 2c+1)
- win_last  out  1  asserted with win_valid for the final window of a frame

## Operation
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on cycles with in_valid=1; cycles with in_valid=0 are ignored entirely, with no state change.
- On an accepted pixel, col increments. At col=IMG_W-1 it wraps to 0 and row increments. At row=IMG_H-1, col=IMG_W-1 both wrap to 0, so the next pixel starts a new frame with no gap required.
- Line buffer: IMG_W x DATA_W register array.
  - Even rows: every accepted pixel is written to line_buf[col].
  - Odd rows: the line buffer is read only, never written.
- Odd rows, even col: the pixel is held in a bottom-left register bl.
- Odd rows, odd col: on the next clock edge, drive:
  - win0 = line_buf[col-1]
  - win1 = line_buf[col]
  - win2 = bl
  - win3 = in_data
  - win_valid = 1
  - win_last = 1 only if row=IMG_H-1 and col=IMG_W-1
- win0..win3 hold their last values until the next window. win_valid and win_last return to 0 the following cycle unless another window completes.
- Values pass through unmodified. No arithmetic, saturation or sign change; -128 is preserved bit-exact.
- Window count per frame: (IMG_W/2)*(IMG_H/2).

## Timing
- Reset values: win_valid=0, win_last=0, win0..win3=0, col=0, row=0, bl=0. Line-buffer contents are don't-care, because every entry is written on an even row before it is read.
- Latency: the window appears exactly 1 cycle after the accepted pixel that completes it (the bottom-right pixel).
- Maximum rate: one window every 2 accepted pixels on odd rows. No backpressure; the downstream stage must accept every pulse.
- rst asserted mid-frame: in the next cycle all outputs are at their reset values. Any partial window is discarded. The first accepted pixel after rst is deasserted is treated as row 0, col 0.
- rst has priority over in_valid in the same cycle; that pixel is dropped.
- in_valid gaps between the top and bottom rows of a window do not corrupt it, because buffered values persist.

## Test plan
- IMG_W=4, IMG_H=4, inputs 0..15 back-to-back:
  - windows (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15)
  - win_valid one cycle after inputs 5, 7, 13 and 15
  - win_last only with (10,11,14,15)
- Signed extremes, IMG_W=2, IMG_H=2, inputs -128, 127, -1, 0 -> win0=-128, win1=127, win2=-1, win3=0 (hex 80, 7F, FF, 00).
- Same stream as the first test, with in_valid=0 inserted for 3 cycles after every pixel -> identical windows, each one cycle after its completing pixel, with no spurious win_valid.
- Two frames back-to-back (0..15 then 100..115, IMG 4x4) -> 8 windows; second frame's first window is (100,101,104,105); win_last once per frame.
- rst asserted for 1 cycle after input 6 of the first test, then 0..15 resent -> no window output from the aborted frame after reset; the full 4-window sequence follows correctly.
- Default 24x24 with random pixels -> exactly 144 windows, each equal to the golden 2x2 block extraction; win_last on window 144 only.
